// File: rtl/div_32_seq_pkg.sv
// Shared types and constants for the sequential signed 32-bit divider.
//   state_t     : controller states (IDLE, RUN, FIX)
//   op_flags_t  : per-operation flags latched on the load edge
//   twos_neg()  : two's-complement negate shared by abs and result fix-up
//   abs_val()   : magnitude of a signed operand, returned unsigned
package div_32_seq_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DIV_ITERS  = 32;
    localparam int unsigned DIV_CYCLES = 34;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    typedef struct packed {
        logic neg_a;
        logic neg_b;
        logic div_zero;
    } op_flags_t;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // -2^31 maps to 32'h8000_0000, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? twos_neg(x) : x;
    endfunction

endpackage

// File: rtl/div_32_seq_if.sv
// Divider command/result bus.
//   master : drives ctrl_DIV and the operands, receives results
//   slave  : the divider side
interface div_32_seq_if;
    import div_32_seq_pkg::*;

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_remainder, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_remainder, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_32_seq_comp.sv
// Cascadable 32-bit unsigned magnitude comparator (comp_32).
//   eq1, gt1 : equal / greater from the more significant stage
//   a, b     : operands compared unsigned
//   eq0_c    : combinational a==b, qualified by eq1
//   gt0_c    : combinational a>b, or already greater upstream
module div_32_seq_comp
    import div_32_seq_pkg::*;
(
    input  logic             eq1,
    input  logic             gt1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq0_c,
    output logic             gt0_c
);

    assign eq0_c = eq1 & (a == b);
    assign gt0_c = gt1 | (eq1 & (a > b));

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle signed 32-bit restoring divider, one quotient bit per clock.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any operation in flight
//   bus     : slave side of div_32_seq_if (start, operands, results, busy)
// Fixed latency: load edge, 32 iteration edges, one sign fix-up edge.
module div_32_seq
    import div_32_seq_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    div_32_seq_if.slave   bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] r_q, q_q, b_abs_q;
    op_flags_t        flags_q;
    logic [WIDTH-1:0] result_q, remainder_q;
    logic             exception_q, rdy_q, busy_q;

    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] diff;
    logic             eq_c, gt_c, ge;

    // Shift the next dividend bit into the partial remainder.
    assign trial = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign diff  = trial + ~b_abs_q + WIDTH'(1);

    div_32_seq_comp u_comp_32 (
        .eq1   (1'b1),
        .gt1   (1'b0),
        .a     (trial),
        .b     (b_abs_q),
        .eq0_c (eq_c),
        .gt0_c (gt_c)
    );

    assign ge = eq_c | gt_c;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state; a start strobe wins in every state.
    always_comb begin
        state_d = state_q;
        if (bus.ctrl_DIV) begin
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN:   if (count_q == CNT_W'(DIV_ITERS - 1)) state_d = S_FIX;
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            b_abs_q     <= '0;
            flags_q     <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;

            // Fix-up completes even if a new start arrives on the same edge.
            if (state_q == S_FIX) begin
                rdy_q  <= 1'b1;
                busy_q <= 1'b0;
                if (flags_q.div_zero) begin
                    result_q    <= '0;
                    remainder_q <= '0;
                    exception_q <= 1'b1;
                end else begin
                    result_q    <= (flags_q.neg_a ^ flags_q.neg_b) ? twos_neg(q_q) : q_q;
                    remainder_q <= flags_q.neg_a ? twos_neg(r_q) : r_q;
                    exception_q <= 1'b0;
                end
            end

            if (bus.ctrl_DIV) begin
                b_abs_q          <= abs_val(bus.data_operandB);
                q_q              <= abs_val(bus.data_operandA);
                r_q              <= '0;
                count_q          <= '0;
                flags_q.neg_a    <= bus.data_operandA[WIDTH-1];
                flags_q.neg_b    <= bus.data_operandB[WIDTH-1];
                flags_q.div_zero <= (bus.data_operandB == '0);
                busy_q           <= 1'b1;
            end else if (state_q == S_RUN) begin
                r_q     <= ge ? diff : trial;
                q_q     <= {q_q[WIDTH-2:0], ge};
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_remainder = remainder_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule
